// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: control-flow type
// encoding, counter reset/allocation values, BTB entry layout.
package bp_pkg;

    typedef enum logic [1:0] {
        BR   = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2,
        RET  = 2'd3
    } ex_type_e;

    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_ALLOC = 2'b10;

    // Tag is stored zero-extended into a fixed-width field so the struct does
    // not depend on the top-level PC/index parameters.
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        ex_type_e             br_type;
        logic [31:0]          target;
        logic [1:0]           cnt;
    } btb_entry_t;

    // Two-bit saturating counter step.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signals between pipeline and predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if import bp_pkg::*; #(
    parameter int PC_W = 9
) ();
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;

    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    ex_type_e        ex_type;
    logic            ex_is_call;
    logic            ex_taken;
    logic [31:0]     ex_target;
    logic            ex_pred_taken;
    logic [31:0]     ex_pred_target;

    logic            mispredict;
    logic [31:0]     redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_type, ex_is_call, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_type, ex_is_call, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/bp_ras.sv
// Circular return-address stack. Push when full overwrites the oldest entry,
// pop when empty is ignored, push+pop together replaces the top.
module bp_ras #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      stack_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, top_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;

    assign top_ptr = sp_q - PTR_W'(1);
    assign top_o   = stack_q[top_ptr];
    assign empty_o = (cnt_q == '0);

    // Next pointer/occupancy and which slot (if any) gets written.
    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = sp_q;
        if (push_i && pop_i && !empty_o) begin
            wr_en  = 1'b1;
            wr_ptr = top_ptr;
        end else if (push_i) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            sp_d  = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the stack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage; contents are meaningless while the stack is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_ptr] <= push_data_i;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, zero-latency fetch lookup and
// execute-stage update/mispredict detection. Optional return-address stack
// is built when BP_RAS_EN is defined; otherwise RET predicts like JALR.
module branch_predictor import bp_pkg::*; #(
    parameter int PC_W      = 9,
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    btb_entry_t       btb_q [ENTRIES];
    logic [IDX_W-1:0] f_idx, x_idx;
    logic [TAG_W-1:0] f_tag, x_tag;
    btb_entry_t       f_ent, x_ent, x_ent_d;
    logic             f_hit, x_hit, wr_en;
    logic             lk_taken;
    logic [31:0]      lk_target;
    logic [31:0]      seq_pc;

    assign f_idx  = bus.if_pc[IDX_W+1:2];
    assign f_tag  = bus.if_pc[PC_W-1:IDX_W+2];
    assign x_idx  = bus.ex_pc[IDX_W+1:2];
    assign x_tag  = bus.ex_pc[PC_W-1:IDX_W+2];
    assign f_ent  = btb_q[f_idx];
    assign x_ent  = btb_q[x_idx];
    assign f_hit  = f_ent.valid && (f_ent.tag == TAG_MAX_W'(f_tag));
    assign x_hit  = x_ent.valid && (x_ent.tag == TAG_MAX_W'(x_tag));
    assign seq_pc = 32'(bus.ex_pc) + 32'd4;

`ifdef BP_RAS_EN
    logic        ras_push, ras_pop, ras_empty;
    logic [31:0] ras_top;
    logic        unused_ok;

    assign ras_push  = bus.ex_valid && bus.ex_is_call;
    assign ras_pop   = bus.ex_valid && (bus.ex_type == RET);
    assign unused_ok = ^bus.if_pc[1:0];

    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (seq_pc),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );
`else
    logic unused_ok;
    assign unused_ok = ^{bus.if_pc[1:0], bus.ex_is_call, 32'(RAS_DEPTH)};
`endif

    // Fetch prediction from the current (pre-update) BTB contents.
    always_comb begin
        lk_taken  = 1'b0;
        lk_target = '0;
        if (f_hit) begin
            lk_taken  = (f_ent.br_type != BR) || f_ent.cnt[1];
            lk_target = f_ent.target;
`ifdef BP_RAS_EN
            if ((f_ent.br_type == RET) && !ras_empty) begin
                lk_target = ras_top;
            end
`endif
        end
    end

    // Execute-stage update: train on hit, allocate only on a taken miss.
    always_comb begin
        x_ent_d = x_ent;
        wr_en   = 1'b0;
        if (bus.ex_valid) begin
            if (x_hit) begin
                wr_en           = 1'b1;
                x_ent_d.cnt     = cnt_next(x_ent.cnt, bus.ex_taken);
                x_ent_d.target  = bus.ex_target;
                x_ent_d.br_type = bus.ex_type;
            end else if (bus.ex_taken) begin
                wr_en   = 1'b1;
                x_ent_d = '{valid: 1'b1, tag: TAG_MAX_W'(x_tag), br_type: bus.ex_type,
                            target: bus.ex_target, cnt: CNT_ALLOC};
            end
        end
    end

    // BTB storage; reset invalidates every entry and weakens all counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, br_type: BR, target: '0, cnt: CNT_RESET};
            end
        end else if (wr_en) begin
            btb_q[x_idx] <= x_ent_d;
        end
    end

    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_target;
    assign bus.mispredict  = bus.ex_valid &&
                             ((bus.ex_pred_taken != bus.ex_taken) ||
                              (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : seq_pc;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the predictor kept in plain arrays and a queue.
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int PCW = 9;
    localparam int ENT = 16;
    localparam int RASD = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(PCW)) bus ();

    branch_predictor #(.PC_W(PCW), .ENTRIES(ENT), .RAS_DEPTH(RASD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    ex_type_e    m_type  [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_cnt   [ENT];
    logic [31:0] ras_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        ras_q.delete();
    endfunction

    function automatic void model_pred(input int unsigned pc, output logic tk, output logic [31:0] tg);
        int unsigned i;
        int unsigned t;
        i  = (pc / 4) % ENT;
        t  = pc / (4 * ENT);
        tk = 1'b0;
        tg = 32'd0;
        if (m_valid[i] && m_tag[i] == t) begin
            tk = (m_type[i] != BR) || (m_cnt[i] >= 2);
            tg = m_tgt[i];
`ifdef BP_RAS_EN
            if (m_type[i] == RET && ras_q.size() > 0) tg = ras_q[$];
`endif
        end
    endfunction

    function automatic void model_update(input int unsigned pc, input ex_type_e ty, input logic call,
                                         input logic tk, input logic [31:0] tgt);
        int unsigned i;
        int unsigned t;
        i = (pc / 4) % ENT;
        t = pc / (4 * ENT);
        if (m_valid[i] && m_tag[i] == t) begin
            m_cnt[i]  = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            m_tgt[i]  = tgt;
            m_type[i] = ty;
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_type[i]  = ty;
            m_tgt[i]   = tgt;
            m_cnt[i]   = 2;
        end
`ifdef BP_RAS_EN
        if (call && ty == RET) begin
            if (ras_q.size() > 0) ras_q[ras_q.size() - 1] = pc + 4;
            else ras_q.push_back(pc + 4);
        end else if (call) begin
            ras_q.push_back(pc + 4);
            if (ras_q.size() > RASD) void'(ras_q.pop_front());
        end else if (ty == RET && ras_q.size() > 0) begin
            void'(ras_q.pop_back());
        end
`endif
    endfunction

    // One cycle: drive fetch + EX, check all combinational outputs, clock, update model.
    task automatic step(input int unsigned fpc, input logic v, input int unsigned epc, input ex_type_e ty,
                        input logic call, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
        logic        e_tk;
        logic [31:0] e_tg;
        bus.if_pc          = PCW'(fpc);
        bus.ex_valid       = v;
        bus.ex_pc          = PCW'(epc);
        bus.ex_type        = ty;
        bus.ex_is_call     = call;
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
        #1;
        model_pred(fpc, e_tk, e_tg);
        chk("pred_taken", 32'(bus.pred_taken), 32'(e_tk));
        chk("pred_target", bus.pred_target, e_tg);
        chk("mispredict", 32'(bus.mispredict), 32'(v && ((ptk != tk) || (tk && ptgt != tgt))));
        chk("redirect_pc", bus.redirect_pc, tk ? tgt : epc + 32'd4);
        @(posedge clk);
        if (v) model_update(epc, ty, call, tk, tgt);
        @(negedge clk);
    endtask

    // Lookup with no EX update, against literal expected values.
    task automatic expect_pred(input string tag, input int unsigned fpc, input logic e_tk, input logic [31:0] e_tg);
        bus.if_pc    = PCW'(fpc);
        bus.ex_valid = 1'b0;
        #1;
        chk({tag, "_taken"}, 32'(bus.pred_taken), 32'(e_tk));
        chk({tag, "_target"}, bus.pred_target, e_tg);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.if_pc = '0; bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_type = BR;
        bus.ex_is_call = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        expect_pred("in_reset", 32'h40, 1'b0, 32'h0);
        reset = 1'b0;
        expect_pred("post_reset", 32'h40, 1'b0, 32'h0);

        // Taken BR allocates; same-cycle lookup sees pre-update (miss).
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_pred("br_alloc", 32'h40, 1'b1, 32'h80);

        // Counter walk-down and saturation at 0.
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        expect_pred("nt1", 32'h40, 1'b0, 32'h80);
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
        expect_pred("nt3", 32'h40, 1'b0, 32'h80);
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_pred("sat0_then_t", 32'h40, 1'b0, 32'h80);
        step(32'h40, 1'b1, 32'h40, BR, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_pred("sat0_then_tt", 32'h40, 1'b1, 32'h80);

        // Alias on same index with different tag.
        expect_pred("alias_miss", 32'h140, 1'b0, 32'h0);
        step(32'h140, 1'b1, 32'h140, BR, 1'b0, 1'b1, 32'h1C0, 1'b0, 32'h0);
        expect_pred("alias_hit", 32'h140, 1'b1, 32'h1C0);
        expect_pred("alias_evict", 32'h40, 1'b0, 32'h0);

        // Mispredicted not-taken at the top of the PC range.
        bus.ex_valid = 1'b1; bus.ex_pc = 9'h1FC; bus.ex_type = BR; bus.ex_is_call = 1'b0;
        bus.ex_taken = 1'b0; bus.ex_target = 32'h0; bus.ex_pred_taken = 1'b1; bus.ex_pred_target = 32'h0;
        #1;
        chk("mp_flag", 32'(bus.mispredict), 32'h1);
        chk("mp_redirect", bus.redirect_pc, 32'h200);
        @(negedge clk);
        bus.ex_valid = 1'b0;

        // Reset during a pending update discards it and clears the BTB.
        bus.ex_valid = 1'b1; bus.ex_pc = 9'h48; bus.ex_type = BR;
        bus.ex_taken = 1'b1; bus.ex_target = 32'h90;
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.ex_valid = 1'b0;
        model_reset();
        expect_pred("rst_discard", 32'h48, 1'b0, 32'h0);
        expect_pred("rst_clear", 32'h140, 1'b0, 32'h0);

        // Return handling: RET entry at 0x60, call at 0x10.
        step(32'h60, 1'b1, 32'h60, RET, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
        step(32'h60, 1'b1, 32'h10, JAL, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
`ifdef BP_RAS_EN
        expect_pred("ras_ret", 32'h60, 1'b1, 32'h14);
        for (int k = 0; k < 5; k++) begin
            step(32'h60, 1'b1, 32'h100 + 4 * k, JAL, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        end
        expect_pred("ras_full", 32'h60, 1'b1, 32'h114);
        for (int k = 0; k < 4; k++) begin
            expect_pred("ras_pop", 32'h60, 1'b1, 32'h114 - 4 * k);
            step(32'h60, 1'b1, 32'h60, RET, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
        end
        expect_pred("ras_empty_fallback", 32'h60, 1'b1, 32'h30);
`else
        expect_pred("ret_as_jalr", 32'h60, 1'b1, 32'h30);
`endif

        // Randomized traffic over a small, heavily aliased PC set.
        for (int n = 0; n < 400; n++) begin
            int unsigned fpc, epc;
            ex_type_e    ty;
            logic        call, tk, ptk, v;
            logic [31:0] tgt, ptgt;
            fpc  = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            epc  = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2);
            ty   = ex_type_e'($urandom_range(0, 3));
            call = (ty == JAL || ty == JALR || ty == RET) ? 1'($urandom_range(0, 1)) : 1'b0;
            tk   = (ty == BR) ? 1'($urandom_range(0, 1)) : 1'b1;
            tgt  = ($urandom_range(0, 1) == 1) ? 32'h80 : $urandom;
            ptk  = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
            v    = ($urandom_range(0, 3) != 0);
            step(fpc, v, epc, ty, call, tk, tgt, ptk, ptgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9: fetch/execute PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16: BTB entry count, power of two, at least 2. IDX_W = log2(ENTRIES); PC_W SHALL exceed IDX_W+2.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-stack depth, power of two; used only with BP_RAS_EN.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 if_pc  in  PC_W  fetch-stage PC to predict.
REQ-007 pred_taken  out  1  predict redirect at fetch.
REQ-008 pred_target  out  32  predicted target, zero-extended.
REQ-009 ex_valid  in  1  resolved control-flow instruction present in EX.
REQ-010 ex_pc  in  PC_W  PC of the EX instruction.
REQ-011 ex_type  in  2  control-flow type: BR, JAL, JALR, RET (from package).
REQ-012 ex_is_call  in  1  JAL/JALR writing x1 or x5.
REQ-013 ex_taken, ex_target  in  1, 32  actual outcome and target.
REQ-014 ex_pred_taken, ex_pred_target  in  1, 32  prediction that was carried with the instruction.
REQ-015 mispredict  out  1  flush request.
REQ-016 redirect_pc  out  32  correct next PC.

Function
REQ-017 index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. BTB is direct-mapped; each entry holds valid, tag, type, 32-bit target and a 2-bit counter.
REQ-018 Lookup SHALL be combinational with zero latency. Hit = valid && tag match. On a hit: pred_taken = 1 for JAL/JALR/RET, else counter[1]. On a miss: pred_taken = 0, pred_target = 0.
REQ-019 Update SHALL occur at the clock edge when ex_valid = 1. On a hit, the counter SHALL saturate-increment if ex_taken, else saturate-decrement (limits 0 and 3), and target/type SHALL be rewritten.
REQ-020 On a miss with ex_taken = 1, SHALL allocate the entry, overwriting it, with counter = 2'b10. On a miss with ex_taken = 0, SHALL not allocate.
REQ-021 A simultaneous lookup and update to the same index SHALL return the pre-update contents; there is no bypass.
REQ-022 mispredict = ex_valid && (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != ex_target)), combinational.
REQ-023 redirect_pc = ex_taken ? ex_target : zero-extended ex_pc+4, with 32-bit wrap.

Reset
REQ-024 Asserting reset SHALL clear all valid bits, set all counters to 2'b01, and empty the RAS. Outputs SHALL then be pred_taken = 0 and pred_target = 0; mispredict follows its inputs.
REQ-025 Reset asserted mid-update SHALL discard that update.

Configuration
REQ-026 When BP_RAS_EN is defined:
- An ex_is_call update SHALL push ex_pc+4.
- An ex_type = RET update SHALL pop.
- A RET hit with a non-empty stack SHALL predict the top of stack.
- Push when full SHALL overwrite the oldest entry (circular).
- Pop when empty SHALL be ignored, and prediction SHALL fall back to the BTB target.
- A simultaneous push and pop SHALL replace the top.
REQ-027 When BP_RAS_EN is undefined, no RAS logic SHALL exist and RET SHALL behave as JALR.

Structure
REQ-028 Package bp_pkg SHALL hold the ex_type enum, the counter reset/alloc constants and the BTB entry struct.
REQ-029 The RAS SHALL be the sub-module bp_ras, instantiated only under BP_RAS_EN.

Verification
REQ-030 The bench SHALL cover these directed scenarios (PC_W = 9, ENTRIES = 16):
- Reset, then if_pc = 0x40 -> pred_taken = 0, pred_target = 0.
- BR at 0x40 taken to 0x80 -> next cycle, if_pc = 0x40 gives pred_taken = 1, pred_target = 0x80.
- Three not-taken updates at 0x40 -> pred_taken = 0 and counter = 0; a fourth update keeps counter = 0.
- Alias 0x40/0x140 (same index, different tag) -> the 0x140 lookup misses until allocated, and allocation evicts 0x40.
- ex_pred_taken = 1, ex_taken = 0, ex_pc = 0x1FC -> mispredict = 1, redirect_pc = 0x200.
- BP_RAS_EN: call at 0x10, then RET hit at 0x60 -> pred_target = 0x14; five calls with RAS_DEPTH = 4 -> the oldest entry is lost.
